// File: rtl/text_buffer_pkg.sv
// Shared constants, FSM state type and the shift-add row base helper for text_buffer.
package text_buffer_pkg;

  localparam int         COLS_DEF         = 80;
  localparam int         ROWS_DEF         = 30;
  localparam logic [7:0] DEFAULT_ATTR_DEF = 8'h0F;
  localparam int         BLINK_FRAMES_DEF = 32;

  localparam logic [7:0] CC_BS      = 8'h08;
  localparam logic [7:0] CC_LF      = 8'h0A;
  localparam logic [7:0] CC_FF      = 8'h0C;
  localparam logic [7:0] CC_CR      = 8'h0D;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_ROW
  } state_t;

  // row * cols as a sum of shifted copies of row; cols is a constant so this folds to adders
  function automatic logic [15:0] row_base(input logic [4:0] row, input int cols);
    logic [15:0] acc;
    acc = '0;
    for (int b = 0; b < 16; b++) begin
      if (cols[b]) acc = acc + (16'(row) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port cell store: one write port, one registered read port, old data on collision.
module text_buffer_ram #(
  parameter int DEPTH  = 2400,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk_pixel,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_pixel) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Character/attribute frame store with cursor, control codes and hardware scroll.
// Optional cursor blink (attribute nibble swap) enabled by defining TEXT_BUFFER_CURSOR_EN.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int         COLS         = COLS_DEF,
  parameter int         ROWS         = ROWS_DEF,
  parameter logic [7:0] DEFAULT_ATTR = DEFAULT_ATTR_DEF
`ifdef TEXT_BUFFER_CURSOR_EN
  , parameter int       BLINK_FRAMES = BLINK_FRAMES_DEF
`endif
) (
  input  logic       clk_pixel,
  input  logic       RESETn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic [7:0] in_attr,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic [7:0] character,
  output logic [7:0] attribute,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);

  state_t state, next_state;

  logic [6:0]        cur_col;
  logic [4:0]        cur_row;
  logic [4:0]        top_row;
  logic [ADDR_W-1:0] clr_cnt;

  logic accept, is_printable, advance, scroll;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, raddr_q;
  logic [15:0]       ram_wdata, ram_rdata;

  function automatic logic [4:0] to_phys(input logic [4:0] lrow, input logic [4:0] top);
    logic [5:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
    return sum[4:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return ADDR_W'(row_base(prow, COLS)) + ADDR_W'(col);
  endfunction

  assign accept       = in_valid && in_ready;
  assign is_printable = !(in_char inside {CC_BS, CC_LF, CC_FF, CC_CR});
  assign advance      = accept && ((in_char == CC_LF) ||
                                   (is_printable && cur_col == 7'(COLS - 1)));
  assign scroll       = advance && (cur_row == 5'(ROWS - 1));
  assign in_ready     = (state == IDLE);
  assign busy         = !in_ready;
  assign cursor_col   = cur_col;
  assign cursor_row   = cur_row;

  always_ff @(posedge clk_pixel or negedge RESETn) begin
    if (!RESETn) state <= CLEAR_ALL;
    else         state <= next_state;
  end

  // After a scroll top_row has already moved, so logical ROWS-1 maps to the row being blanked
  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    ram_waddr  = cell_addr(to_phys(cur_row, top_row), cur_col);
    ram_wdata  = {in_attr, in_char};
    case (state)
      CLEAR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
        ram_wdata = {DEFAULT_ATTR, BLANK_CHAR};
        if (clr_cnt == ADDR_W'(CELLS - 1)) next_state = IDLE;
      end
      IDLE: begin
        if (accept) begin
          if (in_char == CC_FF) next_state = CLEAR_ALL;
          else begin
            ram_we = is_printable;
            if (scroll) next_state = CLEAR_ROW;
          end
        end
      end
      CLEAR_ROW: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr(to_phys(5'(ROWS - 1), top_row), 7'd0) + clr_cnt;
        ram_wdata = {DEFAULT_ATTR, BLANK_CHAR};
        if (clr_cnt == ADDR_W'(COLS - 1)) next_state = IDLE;
      end
      default: next_state = CLEAR_ALL;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge RESETn) begin
    if (!RESETn) begin
      cur_col <= '0;
      cur_row <= '0;
      top_row <= '0;
      clr_cnt <= '0;
    end else begin
      if (state != next_state)  clr_cnt <= '0;
      else if (state != IDLE)   clr_cnt <= clr_cnt + 1'b1;

      if (accept) begin
        case (in_char)
          CC_FF: begin
            cur_col <= '0;
            cur_row <= '0;
            top_row <= '0;
          end
          CC_CR: cur_col <= '0;
          CC_BS: if (cur_col != 7'd0) cur_col <= cur_col - 1'b1;
          CC_LF: cur_col <= '0;
          default: begin
            if (cur_col == 7'(COLS - 1)) cur_col <= '0;
            else                         cur_col <= cur_col + 1'b1;
          end
        endcase
        if (advance) begin
          if (scroll) top_row <= (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 1'b1;
          else        cur_row <= cur_row + 1'b1;
        end
      end
    end
  end

  text_buffer_ram #(
    .DEPTH (CELLS),
    .ADDR_W(ADDR_W),
    .DATA_W(16)
  ) u_ram (
    .clk_pixel(clk_pixel),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .raddr    (raddr_q),
    .rdata    (ram_rdata)
  );

  logic       rd_in_range;
  logic [4:0] rd_row;
  logic       live_q1, live_q2, range_q1, range_q2;
  logic [7:0] shown_attr;

  assign rd_in_range = (cx < 10'(COLS * 8)) && (cy < 10'(ROWS * 16));
  assign rd_row      = cy[8:4];

  // Stage 1 registers the address, stage 2 is the RAM's own output register
  always_ff @(posedge clk_pixel or negedge RESETn) begin
    if (!RESETn) begin
      raddr_q  <= '0;
      live_q1  <= 1'b0;
      live_q2  <= 1'b0;
      range_q1 <= 1'b0;
      range_q2 <= 1'b0;
    end else begin
      raddr_q  <= cell_addr(to_phys(rd_row, top_row), cx[9:3]);
      live_q1  <= 1'b1;
      live_q2  <= live_q1;
      range_q1 <= rd_in_range;
      range_q2 <= range_q1;
    end
  end

`ifdef TEXT_BUFFER_CURSOR_EN
  logic [9:0]  cy_prev;
  logic [15:0] frame_cnt;
  logic        blink_phase, match_q1, match_q2;

  always_ff @(posedge clk_pixel or negedge RESETn) begin
    if (!RESETn) begin
      cy_prev     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      match_q1    <= 1'b0;
      match_q2    <= 1'b0;
    end else begin
      cy_prev <= cy;
      if (cy == 10'd0 && cy_prev != 10'd0) begin
        if (frame_cnt == 16'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      match_q1 <= (cx[9:3] == cur_col) && (rd_row == cur_row);
      match_q2 <= match_q1;
    end
  end

  assign shown_attr = (blink_phase && match_q2) ? {ram_rdata[11:8], ram_rdata[15:12]}
                                                : ram_rdata[15:8];
`else
  assign shown_attr = ram_rdata[15:8];
`endif

  always_comb begin
    character = BLANK_CHAR;
    attribute = DEFAULT_ATTR;
    if (live_q2) begin
      if (range_q2) begin
        character = ram_rdata[7:0];
        attribute = shown_attr;
      end else begin
        attribute = 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer: logical-screen model, read-probe scoreboard, clear/scroll timing.
module tb_text_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk_pixel = 1'b0;
  logic       RESETn    = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [7:0] in_char   = 8'h00;
  logic [7:0] in_attr   = 8'h00;
  logic [9:0] cx        = '0;
  logic [9:0] cy        = '0;
  logic [7:0] character, attribute;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  text_buffer dut (
    .clk_pixel (clk_pixel),
    .RESETn    (RESETn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .in_attr   (in_attr),
    .cx        (cx),
    .cy        (cy),
    .character (character),
    .attribute (attribute),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] at;
    int         px;
    int         py;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic       probe_valid = 1'b0;
  logic       pipe1 = 1'b0, pipe2 = 1'b0;

  logic [15:0] model [ROWS][COLS];
  int          m_col, m_row;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Probes launched on a cycle are compared two clocks later, when the DUT presents them
  always @(posedge clk_pixel) begin
    pipe2 = pipe1;
    pipe1 = probe_valid;
    if (pipe2) begin
      #1;
      if (sb.size() == 0) begin
        check_output("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check_output($sformatf("rd_char(%0d,%0d)", mon_e.px, mon_e.py), 32'(character), 32'(mon_e.ch));
        check_output($sformatf("rd_attr(%0d,%0d)", mon_e.px, mon_e.py), 32'(attribute), 32'(mon_e.at));
      end
    end
  end

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = 16'h0F20;
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_advance();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          model[r][c] = model[r + 1][c];
      for (int c = 0; c < COLS; c++)
        model[ROWS - 1][c] = 16'h0F20;
    end
  endtask

  task automatic model_apply(input logic [7:0] ch, input logic [7:0] at);
    case (ch)
      8'h0C: model_clear();
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col--;
      8'h0A: begin
        m_col = 0;
        model_advance();
      end
      default: begin
        model[m_row][m_col] = {at, ch};
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          model_advance();
        end
      end
    endcase
  endtask

  task automatic apply_stimulus(input logic [7:0] ch, input logic [7:0] at);
    int n = 0;
    @(negedge clk_pixel);
    while (!in_ready && n < 5000) begin
      @(negedge clk_pixel);
      n++;
    end
    if (!in_ready) begin
      check_output("ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_char  = ch;
    in_attr  = at;
    @(negedge clk_pixel);
    in_valid = 1'b0;
    model_apply(ch, at);
  endtask

  task automatic probe(input int px, input int py, input logic [7:0] ech, input logic [7:0] eat);
    exp_t e;
    @(negedge clk_pixel);
    cx = 10'(px);
    cy = 10'(py);
    probe_valid = 1'b1;
    e.ch = ech;
    e.at = eat;
    e.px = px;
    e.py = py;
    sb.push_back(e);
  endtask

  task automatic probe_cell(input int c, input int r);
    logic [15:0] w;
    w = model[r][c];
    probe(c * 8 + c % 8, r * 16 + r % 16, w[7:0], w[15:8]);
  endtask

  task automatic drain();
    @(negedge clk_pixel);
    probe_valid = 1'b0;
    repeat (3) @(negedge clk_pixel);
  endtask

  task automatic sweep();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        probe_cell(c, r);
    drain();
  endtask

  task automatic check_cursor(input string tag);
    check_output({tag, "_col"}, 32'(cursor_col), 32'(m_col));
    check_output({tag, "_row"}, 32'(cursor_row), 32'(m_row));
  endtask

  // Called on the negedge after a full clear starts; counts clocks until in_ready rises
  task automatic expect_full_clear(input string tag);
    int n = 0;
    check_output({tag, "_busy"}, 32'(busy), 32'd1);
    while (!in_ready && n < 3000) begin
      @(posedge clk_pixel);
      #1;
      n++;
    end
    check_output({tag, "_cycles"}, 32'(n), 32'd2400);
  endtask

  task automatic expect_scroll(input string tag);
    int n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk_pixel);
      n++;
    end
    check_output({tag, "_ready_low"}, 32'(n), 32'd80);
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk_pixel);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd1);
    check_output("rst_character", 32'(character), 32'h20);
    check_output("rst_attribute", 32'(attribute), 32'h0F);
    check_cursor("rst_cursor");

    RESETn = 1'b1;
    expect_full_clear("init_clear");
    sweep();

    apply_stimulus(8'h41, 8'h1E);
    check_cursor("after_A");
    probe(0, 0, 8'h41, 8'h1E);
    probe(8, 0, 8'h20, 8'h0F);
    probe(639, 479, 8'h20, 8'h0F);
    probe(640, 0, 8'h20, 8'h00);
    probe(0, 480, 8'h20, 8'h00);
    probe(1023, 1023, 8'h20, 8'h00);
    drain();

    apply_stimulus(8'h0D, 8'h00);
    check_cursor("after_cr");
    for (int i = 0; i < COLS; i++)
      apply_stimulus(8'(8'h21 + i), 8'(8'h10 + i % 7));
    check_cursor("row0_full");
    probe(632, 5, 8'h70, 8'(8'h10 + 79 % 7));
    drain();

    apply_stimulus(8'h08, 8'h00);
    check_cursor("bs_at_col0");

    for (int i = 0; i < 28 * COLS; i++)
      apply_stimulus(8'(8'h30 + i % 64), 8'(i * 3));
    for (int i = 0; i < 40; i++)
      apply_stimulus(8'(8'h41 + i % 26), 8'(8'hA0 + i));
    check_cursor("row29_partial");
    apply_stimulus(8'h0A, 8'h00);
    expect_scroll("lf_scroll");
    check_cursor("after_lf_scroll");
    sweep();

    for (int i = 0; i < COLS; i++)
      apply_stimulus(8'(8'h61 + i % 26), 8'(8'h50 + i));
    expect_scroll("wrap_scroll");
    check_cursor("after_wrap_scroll");
    sweep();

    apply_stimulus(8'h31, 8'h07);
    apply_stimulus(8'h32, 8'h07);
    apply_stimulus(8'h33, 8'h07);
    apply_stimulus(8'h08, 8'h00);
    check_cursor("bs_mid");

    apply_stimulus(8'h0C, 8'h00);
    expect_full_clear("ff_clear");
    check_cursor("after_ff");
    sweep();

    apply_stimulus(8'h5A, 8'h1E);
    probe(3, 7, 8'h5A, 8'h1E);
    drain();

    for (int i = 0; i < ROWS - 1; i++)
      apply_stimulus(8'h0A, 8'h00);
    check_cursor("at_last_row");
    apply_stimulus(8'h0A, 8'h00);
    repeat (10) @(negedge clk_pixel);
    RESETn = 1'b0;
    #1;
    model_clear();
    check_output("mid_scroll_rst_busy", 32'(busy), 32'd1);
    check_cursor("mid_scroll_rst");
    @(negedge clk_pixel);
    RESETn = 1'b1;
    expect_full_clear("rst_clear");
    sweep();

    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
